// File: rtl/johnson_counter_n_if.sv
// Johnson / one-hot ring counter bundle: control inputs toward the counter, decoded state back.
// The counter (slave) has no backpressure. It steps on every enabled edge.
interface johnson_counter_n_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(2*WIDTH);

    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic [PW-1:0]    phase;
    logic             tc;
    logic             legal;
    logic             err;

    modport master (
        output en, dir, load, load_val,
        input  out, phase, tc, legal, err
    );

    modport slave (
        input  en, dir, load, load_val,
        output out, phase, tc, legal, err
    );
endinterface

// File: rtl/johnson_counter_n.sv
// Parametrised Johnson (MODE 0) / one-hot ring (MODE 1) sequencer with load, direction and self-correction.
// out/err change one edge after en/load. phase/legal/tc are combinational. There is no backpressure, and en gates stepping.
module johnson_counter_n #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    johnson_counter_n_if.slave bus
);
    localparam logic [WIDTH-1:0] RP   = WIDTH'((MODE != 0) ? 1 : 0);
    localparam logic [PW-1:0]    LAST = PW'((MODE == 0) ? 2*WIDTH-1 : WIDTH-1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic [PW-1:0]    ones, trans, idx, phase;
    logic             legal;
    logic [WIDTH-1:0] fwd_val, rev_val;

    always_comb begin
        ones  = '0;
        trans = '0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + PW'(out_q[i]);
            if (out_q[i]) idx = PW'(i);
        end
        for (int i = 0; i < WIDTH-1; i++) begin
            trans = trans + PW'(out_q[i] ^ out_q[i+1]);
        end
        if (MODE == 0) begin
            // A Johnson word is one run of ones and one run of zeros, so it has at most one bit transition.
            // The second half-period (leading ones, trailing zeros) counts up as zeros enter from the LSB.
            legal = (trans <= PW'(1));
            phase = (out_q[WIDTH-1] & ~out_q[0]) ? PW'(2*WIDTH) - ones : ones;
        end else begin
            legal = (ones == PW'(1));
            phase = idx;
        end
        if (!legal) phase = '0;
    end

    assign fwd_val = {out_q[WIDTH-2:0], (MODE == 0) ? ~out_q[WIDTH-1] : out_q[WIDTH-1]};
    assign rev_val = {(MODE == 0) ? ~out_q[0] : out_q[0], out_q[WIDTH-1:1]};

    always_comb begin
        out_d = out_q;
        err_d = 1'b0;
        if (bus.load) begin
            out_d = bus.load_val;
        end else if (bus.en && !legal) begin
            out_d = RP;
            err_d = 1'b1;
        end else if (bus.en) begin
            out_d = bus.dir ? rev_val : fwd_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= RP;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.err   = err_q;
    assign bus.phase = phase;
    assign bus.legal = legal;
    assign bus.tc    = bus.en & legal & ~bus.load &
                       ((~bus.dir & (phase == LAST)) | (bus.dir & (phase == '0)));
endmodule

// File: tb/tb_johnson_counter_n.sv
// Bench for johnson_counter_n. It drives a WIDTH=4 Johnson instance and a WIDTH=5 ring instance from vector tables,
// runs hand-written reset sequences, and applies random stimulus checked against a sequence-table model.
module tb_johnson_counter_n;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    johnson_counter_n_if #(.WIDTH(4)) if4();
    johnson_counter_n_if #(.WIDTH(5)) if5();

    johnson_counter_n #(.WIDTH(4), .MODE(0)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    johnson_counter_n #(.WIDTH(5), .MODE(1)) dut5 (.clk(clk), .reset(reset), .bus(if5.slave));

    typedef struct {
        logic        en;
        logic        dir;
        logic        load;
        logic [31:0] load_val;
        logic        tc;
        logic [31:0] out;
        int          phase;
        logic        legal;
        logic        err;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    vec_t        t4[$];
    vec_t        t5[$];
    logic [31:0] m_out[2];
    logic        m_err[2];
    logic        r_en[2], r_dir[2], r_ld[2];
    logic [31:0] r_lv[2];

    function automatic int wd(input int d);  return (d == 0) ? 4 : 5; endfunction
    function automatic int md(input int d);  return d; endfunction
    function automatic int per(input int d); return (md(d) == 0) ? 2*wd(d) : wd(d); endfunction
    function automatic logic [31:0] rp(input int d); return (md(d) == 0) ? 32'h0 : 32'h1; endfunction
    function automatic logic [31:0] mask(input int w);
        return (w >= 32) ? 32'hffff_ffff : (32'h1 << w) - 32'h1;
    endfunction

    // The p-th word of the sequence, derived from the word shapes rather than from the shift rules.
    function automatic logic [31:0] seq_val(input int w, input int m, input int p);
        if (m == 1) return 32'h1 << p;
        if (p <= w) return (32'h1 << p) - 32'h1;
        return mask(w) & ~((32'h1 << (p - w)) - 32'h1);
    endfunction

    task automatic model_dec(input int d, input logic [31:0] v, output logic lg, output int ph);
        lg = 1'b0;
        ph = 0;
        for (int p = 0; p < per(d); p++) begin
            if (seq_val(wd(d), md(d), p) == v) begin
                lg = 1'b1;
                ph = p;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic en, input logic dir, input logic load, input logic [31:0] lv);
        if (d == 0) begin
            if4.en = en; if4.dir = dir; if4.load = load; if4.load_val = lv[3:0];
        end else begin
            if5.en = en; if5.dir = dir; if5.load = load; if5.load_val = lv[4:0];
        end
    endtask

    task automatic rd(input int d, output logic [31:0] o, output int ph, output logic lg,
                      output logic t, output logic e);
        if (d == 0) begin
            o = 32'(if4.out); ph = int'(if4.phase); lg = if4.legal; t = if4.tc; e = if4.err;
        end else begin
            o = 32'(if5.out); ph = int'(if5.phase); lg = if5.legal; t = if5.tc; e = if5.err;
        end
    endtask

    task automatic chk_all(input string nm, input int d, input logic [31:0] o_x, input int ph_x,
                           input logic lg_x, input logic t_x, input logic e_x);
        logic [31:0] o; int ph; logic lg, t, e;
        rd(d, o, ph, lg, t, e);
        chk({nm, ".out"},   o, o_x);
        chk({nm, ".phase"}, ph, ph_x);
        chk({nm, ".legal"}, 32'(lg), 32'(lg_x));
        chk({nm, ".tc"},    32'(t), 32'(t_x));
        chk({nm, ".err"},   32'(e), 32'(e_x));
    endtask

    function automatic vec_t V(input logic en, input logic dir, input logic load, input logic [31:0] lv,
                               input logic tc, input logic [31:0] o, input int ph, input logic lg, input logic er);
        vec_t v;
        v.en = en; v.dir = dir; v.load = load; v.load_val = lv;
        v.tc = tc; v.out = o; v.phase = ph; v.legal = lg; v.err = er;
        return v;
    endfunction

    // tc is checked with the new inputs before the edge. The state is checked after the edge.
    task automatic apply(input int d, input vec_t v, input int n);
        logic [31:0] o; int ph; logic lg, t, e;
        @(negedge clk);
        drive(d, v.en, v.dir, v.load, v.load_val);
        #1;
        rd(d, o, ph, lg, t, e);
        chk($sformatf("d%0d v%0d tc", d, n), 32'(t), 32'(v.tc));
        @(posedge clk);
        #1;
        rd(d, o, ph, lg, t, e);
        chk($sformatf("d%0d v%0d out", d, n), o, v.out);
        chk($sformatf("d%0d v%0d phase", d, n), ph, v.phase);
        chk($sformatf("d%0d v%0d legal", d, n), 32'(lg), 32'(v.legal));
        chk($sformatf("d%0d v%0d err", d, n), 32'(e), 32'(v.err));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic lg;
        int   ph;
        logic et;
        logic [31:0] o; int aph; logic alg, at, ae;

        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 reset = 1'b0;
        #2;
        chk_all("reset4", 0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
        chk_all("reset5", 1, 32'h1, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Johnson W=4: forward wrap, reverse wrap, hold, load priority, illegal hold then correct.
        t4.push_back(V(1,0,0,0,0, 'b0001,1,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0011,2,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0111,3,1,0));
        t4.push_back(V(1,0,0,0,0, 'b1111,4,1,0));
        t4.push_back(V(1,0,0,0,0, 'b1110,5,1,0));
        t4.push_back(V(1,0,0,0,0, 'b1100,6,1,0));
        t4.push_back(V(1,0,0,0,0, 'b1000,7,1,0));
        t4.push_back(V(1,0,0,0,1, 'b0000,0,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0001,1,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0011,2,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0111,3,1,0));
        t4.push_back(V(1,1,0,0,0, 'b0011,2,1,0));
        t4.push_back(V(1,1,0,0,0, 'b0001,1,1,0));
        t4.push_back(V(1,1,0,0,0, 'b0000,0,1,0));
        t4.push_back(V(1,1,0,0,1, 'b1000,7,1,0));
        for (int i = 0; i < 5; i++) t4.push_back(V(0,0,0,0,0, 'b1000,7,1,0));
        t4.push_back(V(1,0,1,'b1100,0, 'b1100,6,1,0));
        t4.push_back(V(0,0,1,'b0101,0, 'b0101,0,0,0));
        for (int i = 0; i < 3; i++) t4.push_back(V(0,1,0,0,0, 'b0101,0,0,0));
        t4.push_back(V(1,1,0,0,0, 'b0000,0,1,1));
        t4.push_back(V(1,0,0,0,0, 'b0001,1,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0011,2,1,0));
        t4.push_back(V(1,0,0,0,0, 'b0111,3,1,0));
        t4.push_back(V(1,0,0,0,0, 'b1111,4,1,0));
        t4.push_back(V(1,0,0,0,0, 'b1110,5,1,0));
        foreach (t4[i]) apply(0, t4[i], i);

        // Asynchronous reset in mid-cycle, held across an edge, then released with en high.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_all("arst4", 0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
        chk_all("arst5", 1, 32'h1, 0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("arst4_held", 0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("arst4_restart", 0, 32'h1, 1, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Ring W=5.
        t5.push_back(V(1,0,0,0,0, 'b00010,1,1,0));
        t5.push_back(V(1,0,0,0,0, 'b00100,2,1,0));
        t5.push_back(V(1,0,0,0,0, 'b01000,3,1,0));
        t5.push_back(V(1,0,0,0,0, 'b10000,4,1,0));
        t5.push_back(V(1,0,0,0,1, 'b00001,0,1,0));
        t5.push_back(V(1,1,0,0,1, 'b10000,4,1,0));
        t5.push_back(V(1,1,0,0,0, 'b01000,3,1,0));
        t5.push_back(V(0,0,1,'b00110,0, 'b00110,0,0,0));
        t5.push_back(V(1,0,0,0,0, 'b00001,0,1,1));
        t5.push_back(V(0,0,0,0,0, 'b00001,0,1,0));
        t5.push_back(V(0,1,1,'b00000,0, 'b00000,0,0,0));
        t5.push_back(V(1,1,0,0,0, 'b00001,0,1,1));
        t5.push_back(V(1,1,0,0,1, 'b10000,4,1,0));
        foreach (t5[i]) apply(1, t5[i], i);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Random stimulus on both instances against the sequence-table model.
        @(negedge clk);
        reset = 1'b0;
        #1 reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_out[d] = rp(d);
            m_err[d] = 1'b0;
        end
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                r_en[d]  = ($urandom_range(0, 3) != 0);
                r_dir[d] = 1'($urandom_range(0, 1));
                r_ld[d]  = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 1) != 0)
                    r_lv[d] = seq_val(wd(d), md(d), int'($urandom_range(0, per(d) - 1)));
                else
                    r_lv[d] = $urandom & mask(wd(d));
                drive(d, r_en[d], r_dir[d], r_ld[d], r_lv[d]);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                model_dec(d, m_out[d], lg, ph);
                et = r_en[d] & lg & ~r_ld[d] & ((!r_dir[d] && ph == per(d) - 1) || (r_dir[d] && ph == 0));
                rd(d, o, aph, alg, at, ae);
                chk($sformatf("rnd%0d d%0d out", it, d),   o, m_out[d]);
                chk($sformatf("rnd%0d d%0d err", it, d),   32'(ae), 32'(m_err[d]));
                chk($sformatf("rnd%0d d%0d phase", it, d), aph, ph);
                chk($sformatf("rnd%0d d%0d legal", it, d), 32'(alg), 32'(lg));
                chk($sformatf("rnd%0d d%0d tc", it, d),    32'(at), 32'(et));
            end
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                #1 reset = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    m_out[d] = rp(d);
                    m_err[d] = 1'b0;
                end
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                model_dec(d, m_out[d], lg, ph);
                m_err[d] = 1'b0;
                if (r_ld[d]) begin
                    m_out[d] = r_lv[d];
                end else if (r_en[d] && !lg) begin
                    m_out[d] = rp(d);
                    m_err[d] = 1'b1;
                end else if (r_en[d]) begin
                    m_out[d] = seq_val(wd(d), md(d), r_dir[d] ? (ph + per(d) - 1) % per(d) : (ph + 1) % per(d));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
